// File: rtl/autosym_pkg.sv
// Shared types and defaults for the autosym input-reduction block.
package autosym_pkg;

    localparam int unsigned N_IN_DEF  = 16;
    localparam int unsigned N_OUT_DEF = 7;
    localparam int unsigned VC_W      = 16;

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Config address width: rows 0..n_out-1 plus one offset slot at n_out.
    function automatic int unsigned aw_calc(input int unsigned n_out);
        return (n_out < 1) ? 1 : $clog2(n_out + 1);
    endfunction

endpackage

// File: rtl/autosym_parity.sv
// One output bit of the reduction: parity of the masked input, flipped by the offset bit.
module autosym_parity #(
    parameter int unsigned N_IN = 16
) (
    input  logic [N_IN-1:0] i_row,
    input  logic [N_IN-1:0] i_data,
    input  logic            i_ofs,
    output logic            o_par_c
);

    assign o_par_c = (^(i_row & i_data)) ^ i_ofs;

endmodule

// File: rtl/autosym_reducer.sv
// Affine GF(2) reduction of an N_IN-bit vector onto N_OUT bits, with a
// configurable matrix/offset and a CFG/RUN/DRAIN streaming controller.
module autosym_reducer
    import autosym_pkg::*;
#(
    parameter  int unsigned N_IN  = N_IN_DEF,
    parameter  int unsigned N_OUT = N_OUT_DEF,
    localparam int unsigned AW    = aw_calc(N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [N_IN-1:0]  cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    output logic             busy,
    output logic [VC_W-1:0]  vec_count
);

    state_e            r_state;
    state_e            w_next_state;
    logic              w_in_ready;
    logic              r_out_valid;
    logic [N_OUT-1:0]  r_out_data;
    logic [VC_W-1:0]   r_vec_count;
    logic [N_IN-1:0]   r_row [N_OUT];
    logic [N_OUT-1:0]  r_ofs;
    logic [N_OUT-1:0]  w_result;
    logic              w_accept;
    logic              w_out_hs;
    logic              w_cfg_wr;
    logic              w_start_cfg;

    for (genvar j = 0; j < N_OUT; j++) begin : g_par
        autosym_parity #(.N_IN(N_IN)) u_parity (
            .i_row   (r_row[j]),
            .i_data  (in_data),
            .i_ofs   (r_ofs[j]),
            .o_par_c (w_result[j])
        );
    end

    assign w_accept    = in_valid && w_in_ready;
    assign w_out_hs    = r_out_valid && out_ready;
    assign w_cfg_wr    = (r_state == ST_CFG) && cfg_we;
    assign w_start_cfg = (r_state == ST_CFG) && start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CFG;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and upstream ready; DRAIN exits once nothing is left to hand off
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            ST_CFG: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = (!r_out_valid || out_ready) && !stop;
                if (stop) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_out_valid || out_ready) begin
                    w_next_state = ST_CFG;
                end
            end
            default: begin
                w_next_state = ST_CFG;
            end
        endcase
    end

    // Output slot: a new accept wins over a completing handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Completed-handshake counter, cleared when a run starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_count <= '0;
        end else if (w_start_cfg) begin
            r_vec_count <= '0;
        end else if (w_out_hs && (r_vec_count != {VC_W{1'b1}})) begin
            r_vec_count <= r_vec_count + VC_W'(1);
        end
    end

    // Matrix rows and offset; reset gives the identity projection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                r_row[j] <= N_IN'(1) << j;
            end
            r_ofs <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (w_cfg_wr && (cfg_addr == AW'(j))) begin
                    r_row[j] <= cfg_data;
                end
            end
            if (w_cfg_wr && (cfg_addr == AW'(N_OUT))) begin
                r_ofs <= cfg_data[N_OUT-1:0];
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign vec_count = r_vec_count;
    assign busy      = (r_state != ST_CFG);

endmodule

// File: tb/tb_autosym_reducer.sv
// Directed bench for autosym_reducer with hand-computed expectations.
module tb_autosym_reducer;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        start;
    logic        stop;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_data;
    logic        busy;
    logic [15:0] vec_count;

    int n_cmp;
    int n_err;
    int n_acc;

    autosym_reducer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .vec_count (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_acc = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_vec_count", 32'(vec_count), 32'h0);
        chk("rst_busy",      32'(busy),      32'd0);
        #19 rst_n = 1'b1;
        step();
        #1 chk("cfg_in_ready", 32'(in_ready), 32'd0);

        // Identity projection
        do_start();
        chk("run_busy", 32'(busy), 32'd1);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h00FF;
        #1 chk("run_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("id_valid", 32'(out_valid), 32'd1);
        chk("id_data",  32'(out_data),  32'h7F);
        step();
        chk("id_valid_clr", 32'(out_valid), 32'd0);
        chk("id_count",     32'(vec_count), 32'd1);
        do_stop_idle();
        chk("idle_busy", 32'(busy), 32'd0);

        // Row 0 = 0x0003
        cfg_write(3'd0, 16'h0003);
        do_start();
        chk("start_clr_count", 32'(vec_count), 32'd0);
        in_valid = 1'b1; in_data = 16'h0001;
        step();
        chk("row0_a", 32'(out_data), 32'h01);
        in_data = 16'h0003;
        step();
        chk("row0_b", 32'(out_data), 32'h02);
        in_valid = 1'b0;
        step();
        chk("row0_count", 32'(vec_count), 32'd2);
        do_stop_idle();

        // Offset 0x55, row 0 restored
        cfg_write(3'd0, 16'h0001);
        cfg_write(3'd7, 16'h0055);
        do_start();
        in_valid = 1'b1; in_data = 16'h0000;
        step();
        chk("ofs_zero", 32'(out_data), 32'h55);
        in_data = 16'h007F;
        step();
        chk("ofs_7f", 32'(out_data), 32'h2A);
        in_valid = 1'b0;
        step();

        // Back-pressure: one accept during a 3-cycle stall, then streaming
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
        step();
        chk("stall_first", 32'(out_data), 32'h54);
        in_data = 16'h0002;
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_hold",     32'(out_data), 32'h54);
            step();
        end
        chk("stall_accepts", 32'(n_acc), 32'd0);
        out_ready = 1'b1;
        step();
        chk("stream_0", 32'(out_data), 32'h57);
        in_data = 16'h0004;
        step();
        chk("stream_1", 32'(out_data), 32'h51);
        in_data = 16'h0008;
        step();
        chk("stream_2", 32'(out_data), 32'h5D);
        chk("stream_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("stream_count", 32'(vec_count), 32'd6);

        // cfg_we ignored in RUN; stop with a pending output
        cfg_write(3'd0, 16'hFFFF);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0002;
        step();
        in_valid = 1'b0;
        chk("run_cfg_ignored", 32'(out_data), 32'h57);
        stop = 1'b1;
        #1 chk("stop_in_ready", 32'(in_ready), 32'd0);
        step();
        stop = 1'b0;
        chk("drain_busy",  32'(busy),      32'd1);
        chk("drain_valid", 32'(out_valid), 32'd1);
        step();
        chk("drain_hold", 32'(busy), 32'd1);
        out_ready = 1'b1;
        step();
        chk("drain_done_busy",  32'(busy),      32'd0);
        chk("drain_done_valid", 32'(out_valid), 32'd0);
        chk("drain_count",      32'(vec_count), 32'd7);

        // Reset mid-RUN with an output pending
        do_start();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0000;
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(vec_count), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        step();
        do_start();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h00AA;
        step();
        in_valid = 1'b0;
        chk("post_rst_identity", 32'(out_data), 32'h2A);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/autosym_reducer.md
AUTOSYM_REDUCER -- requirements
Module: autosym_reducer

Interface
REQ-001 SHALL have parameter N_IN, default 16, meaning the width of the original input vector.
REQ-002 SHALL have parameter N_OUT, default 7, meaning the width of the reduced (restriction) vector; legal range 1..15.
REQ-003 SHALL have derived constant AW = clog2(N_OUT+1), meaning the config address width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_we, input, 1 bit: config write strobe.
REQ-007 SHALL have port cfg_addr, input, AW bits: 0..N_OUT-1 selects a matrix row; N_OUT selects the offset register.
REQ-008 SHALL have port cfg_data, input, N_IN bits: row value; for the offset, only bits [N_OUT-1:0] are used.
REQ-009 SHALL have ports start and stop, each input, 1 bit: single-cycle mode commands.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, N_IN): upstream handshake.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, N_OUT): downstream handshake to the restriction logic cone.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than CFG.
REQ-013 SHALL have port vec_count, output, 16 bits: count of completed output handshakes.

Function
REQ-014 SHALL compute out_data[j] = XOR-reduce(row[j] AND in_data) XOR ofs[j] for every j.
REQ-015 SHALL implement states CFG, RUN and DRAIN.
REQ-016 In CFG, SHALL hold in_ready at 0 and SHALL write row[cfg_addr] or ofs on cfg_we; SHALL ignore cfg_addr > N_OUT.
REQ-017 In CFG, start SHALL move the FSM to RUN next cycle and clear vec_count; a cfg_we in the same cycle SHALL still be applied; stop SHALL be ignored.
REQ-018 In RUN, SHALL ignore cfg_we and start, and SHALL drive in_ready = (!out_valid || out_ready) && !stop.
REQ-019 On an in_valid && in_ready handshake, SHALL register the result into out_data and set out_valid next cycle (latency 1).
REQ-020 SHALL hold out_data stable while out_valid && !out_ready, and SHALL sustain one vector per cycle when out_ready is held high.
REQ-021 On an out_valid && out_ready handshake with no new accept, SHALL clear out_valid next cycle.
REQ-022 In RUN, stop SHALL move the FSM to DRAIN next cycle; no input SHALL be accepted in the stop cycle.
REQ-023 In DRAIN, SHALL hold in_ready at 0 and SHALL return to CFG in the cycle after out_valid is 0 or its handshake completes.
REQ-024 SHALL increment vec_count on each output handshake, saturating at 0xFFFF.

Reset
REQ-025 While rst_n is low, SHALL asynchronously set: state CFG, out_valid 0, out_data 0, vec_count 0, ofs 0, and row[j] one-hot at bit j (identity projection).
REQ-026 Reset during RUN or DRAIN SHALL discard any pending output, with no handshake completing.
REQ-027 SHALL release reset synchronously to clk; the first cycle after release behaves as CFG.

Structure
REQ-028 Package autosym_pkg SHALL hold the state enum (CFG, RUN, DRAIN), the N_IN/N_OUT defaults and the AW function.
REQ-029 SHALL instantiate combinational sub-module autosym_parity (one row AND, XOR-reduce, XOR offset bit) N_OUT times.

Verification
REQ-030 Reset, start, in_data=0x00FF -> out_data=0x7F one cycle after accept; vec_count=1 after handshake.
REQ-031 In CFG write row0=0x0003, start; in_data=0x0001 -> out_data[0]=1; in_data=0x0003 -> out_data[0]=0.
REQ-032 Write offset (addr 7) 0x55, start, in_data=0x0000 -> out_data=0x55.
REQ-033 RUN, out_ready=0 for 3 cycles with in_valid=1 -> out_data unchanged, in_ready=0, exactly one vector accepted; release -> streaming at 1 vector/cycle.
REQ-034 Output pending with out_ready=0, pulse stop -> DRAIN, busy=1; raise out_ready -> handshake, then CFG, busy=0; a cfg_we during RUN leaves rows unchanged.
REQ-035 Assert rst_n low mid-RUN with out_valid=1 -> out_valid=0, vec_count=0 and identity rows restored immediately.
